// File: rtl/fetch_decode.sv
// RV32 front end: PC, level-sensitive instruction fetch, decode, and a registered valid/ready bundle to execute.
// Optional define FETCH_DECODE_PERF_EN adds the perf_retired handshake counter port.
module fetch_decode #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          XLEN         = 32
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] pc_out,
    output logic [31:0]     instr,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [2:0]      funct3,
    output logic            funct7_5,
    output logic [1:0]      alu_op,
    output logic            alu_src,
    output logic            we,
    output logic [XLEN-1:0] imm,
    output logic            illegal
`ifdef FETCH_DECODE_PERF_EN
    ,
    output logic [31:0]     perf_retired
`endif
);

    typedef enum logic {S_FETCH = 1'b0, S_VALID = 1'b1} state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t            state_q;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   pc_out_q;
    logic [31:0]       instr_q;
    logic              valid_q;
    logic              f7_q;
    logic [1:0]        alu_op_q;
    logic              alu_src_q;
    logic              we_q;
    logic [XLEN-1:0]   imm_q;
    logic              ill_q;

    // Combinational decode of the word arriving on imem_rdata
    logic              f7_d;
    logic [1:0]        alu_op_d;
    logic              alu_src_d;
    logic              we_d;
    logic [XLEN-1:0]   imm_d;
    logic              ill_d;
    logic [6:0]        opcode;

    assign opcode = imem_rdata[6:0];

    always_comb begin
        f7_d      = 1'b0;
        alu_op_d  = 2'b00;
        alu_src_d = 1'b0;
        we_d      = 1'b0;
        imm_d     = '0;
        ill_d     = 1'b0;
        case (opcode)
            OP_R: begin
                alu_op_d = 2'b10;
                we_d     = 1'b1;
                f7_d     = imem_rdata[30];
            end
            OP_IALU: begin
                alu_op_d  = 2'b10;
                alu_src_d = 1'b1;
                we_d      = 1'b1;
                imm_d     = {{20{imem_rdata[31]}}, imem_rdata[31:20]};
                // only SRAI carries a meaningful bit 30
                f7_d      = (imem_rdata[14:12] == 3'b101) ? imem_rdata[30] : 1'b0;
            end
            OP_LOAD: begin
                alu_src_d = 1'b1;
                we_d      = 1'b1;
                imm_d     = {{20{imem_rdata[31]}}, imem_rdata[31:20]};
            end
            OP_STORE: begin
                alu_src_d = 1'b1;
                imm_d     = {{20{imem_rdata[31]}}, imem_rdata[31:25], imem_rdata[11:7]};
            end
            OP_BRANCH: begin
                alu_op_d = 2'b01;
                imm_d    = {{19{imem_rdata[31]}}, imem_rdata[31], imem_rdata[7],
                            imem_rdata[30:25], imem_rdata[11:8], 1'b0};
            end
            default: ill_d = 1'b1;
        endcase
    end

    logic [XLEN-1:0] redirect_tgt;
    assign redirect_tgt = {redirect_pc[XLEN-1:2], 2'b00};

    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_VECTOR;
            pc_out_q  <= '0;
            instr_q   <= '0;
            valid_q   <= 1'b0;
            f7_q      <= 1'b0;
            alu_op_q  <= 2'b00;
            alu_src_q <= 1'b0;
            we_q      <= 1'b0;
            imm_q     <= '0;
            ill_q     <= 1'b0;
        end else if (redirect_valid) begin
            // Any ack this cycle is dropped; a concurrent handshake has already been taken by execute
            state_q <= S_FETCH;
            pc_q    <= redirect_tgt;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_ack) begin
                        state_q   <= S_VALID;
                        valid_q   <= 1'b1;
                        pc_q      <= pc_q + 32'd4;
                        pc_out_q  <= pc_q;
                        instr_q   <= imem_rdata;
                        f7_q      <= f7_d;
                        alu_op_q  <= alu_op_d;
                        alu_src_q <= alu_src_d;
                        we_q      <= we_d;
                        imm_q     <= imm_d;
                        ill_q     <= ill_d;
                    end
                end
                S_VALID: begin
                    if (out_ready) begin
                        state_q <= S_FETCH;
                        valid_q <= 1'b0;
                    end
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

`ifdef FETCH_DECODE_PERF_EN
    logic [31:0] perf_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            perf_q <= '0;
        else if (valid_q && out_ready)
            perf_q <= perf_q + 32'd1;
    end
    assign perf_retired = perf_q;
`endif

    assign imem_req  = (state_q == S_FETCH);
    assign imem_addr = pc_q;
    assign out_valid = valid_q;
    assign pc_out    = pc_out_q;
    assign instr     = instr_q;
    assign rs1       = instr_q[19:15];
    assign rs2       = instr_q[24:20];
    assign rd        = instr_q[11:7];
    assign funct3    = instr_q[14:12];
    assign funct7_5  = f7_q;
    assign alu_op    = alu_op_q;
    assign alu_src   = alu_src_q;
    assign we        = we_q;
    assign imm       = imm_q;
    assign illegal   = ill_q;

endmodule

// File: doc/fetch_decode.md
Name: fetch_decode

Overview:
Front end of the single-issue RISC-V core. Holds the PC and fetches 32-bit words from instruction memory over a level-sensitive req/ack interface. Decodes each word into the control and operand bundle the execute stage consumes (rs1, rs2, rd, funct3, funct7_5, alu_op, alu_src, we, immediate), then presents that bundle to execute through a registered valid/ready handshake. Accepts a PC redirect from branch resolution.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
XLEN, 32, data/address width. Only 32 is supported.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
imem_req  out  1  fetch request, level
imem_addr  out  32  fetch address (word aligned)
imem_ack  in  1  one-cycle pulse; imem_rdata valid this cycle
imem_rdata  in  32  fetched instruction
redirect_valid  in  1  load new PC, flush current bundle
redirect_pc  in  32  redirect target (bits [1:0] ignored, forced 0)
out_valid  out  1  decoded bundle valid
out_ready  in  1  execute accepts bundle
pc_out  out  32  PC of the decoded instruction
instr  out  32  raw instruction
rs1, rs2, rd  out  5 each  instr[19:15], [24:20], [11:7]
funct3  out  3  instr[14:12]
funct7_5  out  1  see decode table
alu_op  out  2  00 add (ld/st), 01 branch compare, 10 funct-decoded
alu_src  out  1  1 = immediate operand
we  out  1  register-file write enable
imm  out  32  sign-extended immediate
illegal  out  1  unsupported opcode

Behaviour:
- Reset (asynchronous): pc <= RESET_VECTOR, state S_FETCH, and all bundle outputs, out_valid and illegal <= 0. The first imem_req is asserted in the first cycle after reset deasserts.
- imem protocol: imem_req is high only in S_FETCH, with imem_addr = pc. Memory is level-sensitive and carries no outstanding transaction once req drops. imem_addr may change between cycles while req stays high.
- S_FETCH: when imem_ack is high, register the decoded bundle, set out_valid = 1 next cycle, pc <= pc + 4 (wraps modulo 2^32), and go to S_VALID. Without ack, stay in S_FETCH.
- S_VALID: imem_req = 0 and the bundle is held stable. When out_ready is high, set out_valid <= 0 and go to S_FETCH. Throughput is 1 instruction per 2 cycles with a zero-wait memory. Latency from ack to out_valid is 1 cycle.
- Redirect has priority over everything:
  - pc <= {redirect_pc[31:2], 2'b00}, out_valid <= 0, state <= S_FETCH.
  - An ack in the same cycle is discarded and pc is not incremented.
  - A redirect coinciding with out_valid & out_ready: the handshake still completes (execute took the bundle), then the redirect applies.
- Decode, by opcode instr[6:0]:
  - 0110011 R: alu_op=10, alu_src=0, we=1, imm=0, funct7_5=instr[30].
  - 0010011 I-ALU: alu_op=10, alu_src=1, we=1, imm=sext(instr[31:20]). funct7_5=instr[30] only when funct3==101 (SRAI), else 0.
  - 0000011 load: alu_op=00, alu_src=1, we=1, imm=sext(instr[31:20]).
  - 0100011 store: alu_op=00, alu_src=1, we=0, imm=sext({instr[31:25],instr[11:7]}).
  - 1100011 branch: alu_op=01, alu_src=0, we=0, imm=sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
  - Any other opcode: illegal=1, we=0, alu_op=00, alu_src=0, imm=0.
  - For all non-R, non-SRAI cases, funct7_5=0.
  - rs1/rs2/rd/funct3 always come from the raw fields.
  - rd==0 with we=1 is passed through unchanged; the register file ignores writes to x0.

Optional Feature:
FETCH_DECODE_PERF_EN. When defined, adds output port perf_retired[31:0]: it counts out_valid & out_ready handshakes, wraps at 2^32, and is reset to 0. When undefined, the port and counter are absent and all other behaviour is identical.

Test Plan:
- RESET_VECTOR=0. First fetch at addr 0 is acked with 0x002082b3 (add x5,x1,x2). Required next cycle: out_valid=1, pc_out=0, rs1=1, rs2=2, rd=5, funct3=0, funct7_5=0, alu_op=10, alu_src=0, we=1. After out_ready, imem_addr=4.
- Hold out_ready=0 for 3 cycles after a valid bundle. Required: bundle stable, imem_req=0, pc stays 4. Raising out_ready gives imem_req=1 next cycle.
- Fetch 0xfff00193 (addi x3,x0,-1). Required: alu_src=1, imm=0xFFFFFFFF, rd=3, funct7_5=0, we=1.
- Fetch 0x40208233 (sub x4,x1,x2), then 0x00812423 (sw x8,8(x2)). Required: first has funct7_5=1, alu_op=10. Second has we=0, alu_src=1, imm=8, alu_op=00.
- Assert redirect_valid with redirect_pc=0x103 in S_VALID, then again in a cycle where imem_ack=1. Required both times: out_valid=0 next cycle, imem_addr=0x100, acked data dropped.
- Fetch 0x00000000. Required: illegal=1, we=0, imm=0. Reset asserted mid-S_VALID gives out_valid=0 and pc=RESET_VECTOR immediately (asynchronously).
